operand_loader: RTL and testbench

Upstream stage of the adder/multiplier datapath. Deserialises two operands, A and B, from single-bit serial pins into WIDTH-bit parallel words. Presents each completed word pair to the downstream adder/multiplier stage through a valid/ready handshake. Holds the word stable until the consumer accepts it, so the serial side can be driven directly from the limited chip I/O.

---
 rtl/operand_loader_pkg.sv | 22 ++
 rtl/operand_loader_if.sv | 26 ++
 rtl/operand_loader_pins.sv | 34 +++
 rtl/operand_loader_sipo_shift.sv | 32 +++
 rtl/operand_loader.sv | 101 ++++++++++
 tb/tb_operand_loader.sv | 227 ++++++++++++++++++++++
 6 files changed

// File: rtl/operand_loader_pkg.sv
// Shared types and sizing helpers for the serial operand loader.
// Imported by the loader top and its pin wrapper.
package operand_loader_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bit-counter width for a given operand width.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

    // Counter value at which the last bit of a word is captured.
    function automatic int last_index(input int width);
        return width - 1;
    endfunction

endpackage

// File: rtl/operand_loader_if.sv
// Serial-input / parallel-output bundle between a serial driver and the loader.
// master = driver/consumer side, slave = the loader itself.
interface operand_loader_if #(
    parameter int WIDTH = 8
);
    logic             sdata_a;
    logic             sdata_b;
    logic             shift_en;
    logic             abort;
    logic             out_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             busy;
    logic             overrun;

    modport master (
        output sdata_a, sdata_b, shift_en, abort, out_ready,
        input  a, b, out_valid, busy, overrun
    );

    modport slave (
        input  sdata_a, sdata_b, shift_en, abort, out_ready,
        output a, b, out_valid, busy, overrun
    );
endinterface

// File: rtl/operand_loader_pins.sv
// Pin-level wrapper: maps the packed chip I/O bus onto the loader.
// io_in = {out_ready, abort, shift_en, sdata_b, sdata_a, reset, clk}.
module operand_loader_pins
    import operand_loader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [6:0]       io_in,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun
);
    operand_loader_if #(.WIDTH(WIDTH)) bus ();

    assign bus.sdata_a   = io_in[2];
    assign bus.sdata_b   = io_in[3];
    assign bus.shift_en  = io_in[4];
    assign bus.abort     = io_in[5];
    assign bus.out_ready = io_in[6];

    operand_loader #(.WIDTH(WIDTH)) u_loader (
        .clk   (io_in[0]),
        .reset (io_in[1]),
        .bus   (bus)
    );

    assign a         = bus.a;
    assign b         = bus.b;
    assign out_valid = bus.out_valid;
    assign busy      = bus.busy;
    assign overrun   = bus.overrun;
endmodule

// File: rtl/operand_loader_sipo_shift.sv
// WIDTH-bit serial-in parallel-out register, LSB first: new bits enter at
// the MSB and move toward bit 0, so after WIDTH shifts bit 0 is the first bit.
module sipo_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sdata,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;

    assign q_next[WIDTH-1] = en ? sdata : q_reg[WIDTH-1];

    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_bit
            assign q_next[gi] = en ? q_reg[gi+1] : q_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q = q_reg;
endmodule

// File: rtl/operand_loader.sv
// Deserialises operands A and B and presents each completed pair through a
// valid/ready handshake, holding it stable until accepted.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic               clk,
    input logic               reset,
    operand_loader_if.slave   bus
);
    localparam int               CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(last_index(WIDTH));

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             overrun_reg, overrun_next;
    logic             busy_reg, busy_next;
    logic             shift;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        overrun_next = overrun_reg;
        shift        = 1'b0;

        if (bus.abort) begin
            state_next   = LOAD;
            cnt_next     = '0;
            overrun_next = 1'b0;
        end else begin
            case (state_reg)
                LOAD: begin
                    if (bus.shift_en) begin
                        shift = 1'b1;
                        if (cnt_reg == LAST) begin
                            cnt_next   = '0;
                            state_next = HOLD;
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        // A bit arriving on the acceptance edge starts the next word.
                        state_next = LOAD;
                        if (bus.shift_en) begin
                            shift    = 1'b1;
                            cnt_next = CNT_W'(1);
                        end else begin
                            cnt_next = '0;
                        end
                    end else if (bus.shift_en) begin
                        overrun_next = 1'b1;
                    end
                end
                default: begin
                    state_next = LOAD;
                    cnt_next   = '0;
                end
            endcase
        end

        busy_next = (state_next == LOAD) && (cnt_next != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= LOAD;
            cnt_reg     <= '0;
            overrun_reg <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            overrun_reg <= overrun_next;
            busy_reg    <= busy_next;
        end
    end

    sipo_shift #(.WIDTH(WIDTH)) u_sipo_a (
        .clk   (clk),
        .reset (reset),
        .en    (shift),
        .sdata (bus.sdata_a),
        .q     (bus.a)
    );

    sipo_shift #(.WIDTH(WIDTH)) u_sipo_b (
        .clk   (clk),
        .reset (reset),
        .en    (shift),
        .sdata (bus.sdata_b),
        .q     (bus.b)
    );

    assign bus.out_valid = (state_reg == HOLD);
    assign bus.busy      = busy_reg;
    assign bus.overrun   = overrun_reg;
endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench: stimulus queues expected {a,b} pairs, a monitor checks each
// presented word and its stability; control flags are checked inline.
module tb_operand_loader;
    logic clk;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    operand_loader_if #(.WIDTH(4))  if4  ();
    operand_loader_if #(.WIDTH(2))  if2  ();
    operand_loader_if #(.WIDTH(16)) if16 ();

    operand_loader #(.WIDTH(4))  dut4  (.clk(clk), .reset(rst), .bus(if4));
    operand_loader #(.WIDTH(2))  dut2  (.clk(clk), .reset(rst), .bus(if2));
    operand_loader #(.WIDTH(16)) dut16 (.clk(clk), .reset(rst), .bus(if16));

    logic [6:0] io_in;
    logic [3:0] pw_a, pw_b;
    logic       pw_valid, pw_busy, pw_overrun;
    assign io_in = {if4.out_ready, if4.abort, if4.shift_en, if4.sdata_b, if4.sdata_a, rst, clk};

    operand_loader_pins #(.WIDTH(4)) dut_pins (
        .io_in(io_in), .a(pw_a), .b(pw_b),
        .out_valid(pw_valid), .busy(pw_busy), .overrun(pw_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected words per instance: 0=w4, 1=w2, 2=w16, 3=pins; packed {a,b}.
    logic [31:0] q0[$], q1[$], q2[$], q3[$];
    logic [15:0] a_s [4];
    logic [15:0] b_s [4];
    logic        v_s [4];
    assign a_s[0] = 16'(if4.a);  assign b_s[0] = 16'(if4.b);  assign v_s[0] = if4.out_valid;
    assign a_s[1] = 16'(if2.a);  assign b_s[1] = 16'(if2.b);  assign v_s[1] = if2.out_valid;
    assign a_s[2] = if16.a;      assign b_s[2] = if16.b;      assign v_s[2] = if16.out_valid;
    assign a_s[3] = 16'(pw_a);   assign b_s[3] = 16'(pw_b);   assign v_s[3] = pw_valid;

    bit          v_prev [4];
    bit          have_held [4];
    logic [31:0] held [4];
    string       names [4] = '{"w4", "w2", "w16", "pins"};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("[TB] ok   %s: %h", name, act);
        end
    endtask

    task automatic push(input int i, input logic [15:0] ea, input logic [15:0] eb);
        case (i)
            0: q0.push_back({ea, eb});
            1: q1.push_back({ea, eb});
            2: q2.push_back({ea, eb});
            default: q3.push_back({ea, eb});
        endcase
    endtask

    task automatic mon_check(input int i);
        logic [31:0] exp;
        bit          have;
        exp  = '0;
        have = 1'b0;
        if (v_s[i] && !v_prev[i]) begin
            case (i)
                0: if (q0.size() > 0) begin exp = q0.pop_front(); have = 1'b1; end
                1: if (q1.size() > 0) begin exp = q1.pop_front(); have = 1'b1; end
                2: if (q2.size() > 0) begin exp = q2.pop_front(); have = 1'b1; end
                default: if (q3.size() > 0) begin exp = q3.pop_front(); have = 1'b1; end
            endcase
            if (!have) begin
                tests++;
                fails++;
                $display("[TB] FAIL %s word: unexpected a=%h b=%h, none expected", names[i], a_s[i], b_s[i]);
            end else begin
                chk({names[i], " word"}, {a_s[i], b_s[i]}, exp);
            end
            held[i]      = exp;
            have_held[i] = have;
        end else if (v_s[i] && have_held[i]) begin
            chk({names[i], " held stable"}, {a_s[i], b_s[i]}, held[i]);
        end
        v_prev[i] = v_s[i];
    endtask

    always begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) mon_check(i);
    end

    // One W4 cycle: drive on the falling edge, return 1 time unit after the rising edge.
    task automatic cyc4(input logic sa, input logic sb, input logic sh, input logic ab, input logic rdy);
        @(negedge clk);
        if4.sdata_a = sa; if4.sdata_b = sb; if4.shift_en = sh; if4.abort = ab; if4.out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  bb_a [3] = '{4'h9, 4'h5, 4'hE};
    logic [3:0]  bb_b [3] = '{4'h3, 4'hC, 4'h7};
    logic [3:0]  wa, wb;
    logic [31:0] ra, rb, sa16, sb16;

    initial begin
        rst = 1'b1;
        if4.sdata_a = 0; if4.sdata_b = 0; if4.shift_en = 0; if4.abort = 0; if4.out_ready = 0;
        if2.sdata_a = 0; if2.sdata_b = 0; if2.shift_en = 0; if2.abort = 0; if2.out_ready = 0;
        if16.sdata_a = 0; if16.sdata_b = 0; if16.shift_en = 0; if16.abort = 0; if16.out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset a", 32'(if4.a), 0);
        chk("reset b", 32'(if4.b), 0);
        chk("reset out_valid", 32'(if4.out_valid), 0);
        chk("reset busy", 32'(if4.busy), 0);
        chk("reset overrun", 32'(if4.overrun), 0);
        rst = 1'b0;

        // Basic load: A = 1,0,1,1 -> D, B = 0,1,1,0 -> 6
        wa = 4'hD; wb = 4'h6;
        push(0, 16'(wa), 16'(wb)); push(3, 16'(wa), 16'(wb));
        for (int k = 0; k < 4; k++) begin
            cyc4(wa[k], wb[k], 1'b1, 1'b0, 1'b0);
            if (k == 0) begin
                chk("basic busy after bit0", 32'(if4.busy), 1);
                chk("pins busy after bit0", 32'(pw_busy), 1);
            end
            chk($sformatf("basic out_valid cycle %0d", k + 1), 32'(if4.out_valid), (k == 3) ? 1 : 0);
        end
        chk("basic busy at hold", 32'(if4.busy), 0);
        chk("basic a", 32'(if4.a), 32'hD);
        chk("basic b", 32'(if4.b), 32'h6);

        // Hold and overrun
        cyc4(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc4(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("hold overrun", 32'(if4.overrun), 1);
        chk("pins overrun", 32'(pw_overrun), 1);
        chk("hold out_valid", 32'(if4.out_valid), 1);
        chk("hold a", 32'(if4.a), 32'hD);
        chk("hold b", 32'(if4.b), 32'h6);
        cyc4(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("accept out_valid", 32'(if4.out_valid), 0);
        chk("accept overrun sticky", 32'(if4.overrun), 1);

        // Back-to-back, 12 cycles, ready tied high
        for (int w = 0; w < 3; w++) begin
            push(0, 16'(bb_a[w]), 16'(bb_b[w]));
            push(3, 16'(bb_a[w]), 16'(bb_b[w]));
        end
        for (int k = 0; k < 12; k++) begin
            wa = bb_a[k / 4]; wb = bb_b[k / 4];
            cyc4(wa[k % 4], wb[k % 4], 1'b1, 1'b0, 1'b1);
            chk($sformatf("b2b out_valid cycle %0d", k + 1), 32'(if4.out_valid), ((k + 1) % 4 == 0) ? 1 : 0);
        end
        cyc4(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("b2b drain out_valid", 32'(if4.out_valid), 0);
        chk("b2b drain busy", 32'(if4.busy), 0);

        // Abort mid-word, then a word built only from the following 4 bits
        cyc4(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc4(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("abort pre busy", 32'(if4.busy), 1);
        cyc4(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("abort busy", 32'(if4.busy), 0);
        chk("abort overrun cleared", 32'(if4.overrun), 0);
        chk("abort out_valid", 32'(if4.out_valid), 0);
        wa = 4'hE; wb = 4'h9;
        push(0, 16'(wa), 16'(wb)); push(3, 16'(wa), 16'(wb));
        for (int k = 0; k < 4; k++) cyc4(wa[k], wb[k], 1'b1, 1'b0, 1'b0);
        chk("post-abort out_valid", 32'(if4.out_valid), 1);
        cyc4(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("post-abort overrun", 32'(if4.overrun), 1);

        // Reset during HOLD with overrun set
        rst = 1'b1;
        cyc4(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("midreset a", 32'(if4.a), 0);
        chk("midreset b", 32'(if4.b), 0);
        chk("midreset out_valid", 32'(if4.out_valid), 0);
        chk("midreset busy", 32'(if4.busy), 0);
        chk("midreset overrun", 32'(if4.overrun), 0);
        rst = 1'b0;

        // First post-reset shift is bit 0; abort beats out_ready+shift_en in HOLD
        wa = 4'h2; wb = 4'hB;
        push(0, 16'(wa), 16'(wb)); push(3, 16'(wa), 16'(wb));
        for (int k = 0; k < 4; k++) cyc4(wa[k], wb[k], 1'b1, 1'b0, 1'b0);
        chk("prio out_valid", 32'(if4.out_valid), 1);
        cyc4(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("prio abort out_valid", 32'(if4.out_valid), 0);
        chk("prio abort busy", 32'(if4.busy), 0);
        cyc4(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Width sweep: WIDTH=2 and WIDTH=16 with random LSB-first streams
        ra = $urandom; rb = $urandom; sa16 = $urandom; sb16 = $urandom;
        for (int j = 0; j < 16; j++) push(1, 16'(ra[2*j +: 2]), 16'(rb[2*j +: 2]));
        for (int j = 0; j < 2; j++)  push(2, sa16[16*j +: 16], sb16[16*j +: 16]);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if2.sdata_a = ra[k];    if2.sdata_b = rb[k];    if2.shift_en = 1'b1;  if2.out_ready = 1'b1;
            if16.sdata_a = sa16[k]; if16.sdata_b = sb16[k]; if16.shift_en = 1'b1; if16.out_ready = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("w2 out_valid cycle %0d", k + 1), 32'(if2.out_valid), ((k + 1) % 2 == 0) ? 1 : 0);
            chk($sformatf("w16 out_valid cycle %0d", k + 1), 32'(if16.out_valid), ((k + 1) % 16 == 0) ? 1 : 0);
        end
        @(negedge clk);
        if2.shift_en = 1'b0; if16.shift_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("w2 drained", 32'(if2.out_valid), 0);
        chk("w16 drained", 32'(if16.out_valid), 0);
        chk("w4 queue empty", 32'(q0.size()), 0);
        chk("w2 queue empty", 32'(q1.size()), 0);
        chk("w16 queue empty", 32'(q2.size()), 0);
        chk("pins queue empty", 32'(q3.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
